// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : FSM encoding (IDLE/CALC/DONE)
//   DEF_WIDTH : default operand width
package subtrator_serial_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/subtrator_1bit.sv
// 1-bit full subtractor: d = a - b - bi, bo = borrow out.
// Ports (outputs first): d, bo, a, b, bi.
module subtrator_1bit (
  output logic d,
  output logic bo,
  input  logic a,
  input  logic b,
  input  logic bi
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - Bin, Bout = borrow out of MSB.
// One shared 1-bit subtractor, LSB first, one bit per clock.
// Ports:
//   clk, rst      : clock (rising edge), async active-high reset
//   start         : request, sampled only in IDLE
//   A, B, Bin     : operands, captured when start is accepted
//   D, Bout       : registered result, updated only on entry to DONE
//   busy          : high in CALC and DONE
//   done          : one-cycle pulse when D/Bout are fresh
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] d_sr;   // bits already produced; the current bit completes the word
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             d_bit, bo_bit;
  logic [WIDTH-1:0] d_cat;
  logic             last;

  subtrator_1bit u_fs (
    .d  (d_bit),
    .bo (bo_bit),
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (brw)
  );

  assign d_cat = {d_bit, d_sr};
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr <= A;
          b_sr <= B;
          brw  <= Bin;
          cnt  <= '0;
        end
        CALC: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_cat[WIDTH-1:1];
          brw  <= bo_bit;
          cnt  <= cnt + CNT_W'(1);
          // Result registers move only here so they stay stable through CALC.
          if (last) begin
            D    <= d_cat;
            Bout <= bo_bit;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial at WIDTH=8, 2 and 16.
module tb_subtrator_serial;
  logic clk = 1'b0;
  logic rst;

  logic        st8,  bi8,  bo8,  busy8,  done8;
  logic [7:0]  a8,   b8,   d8;
  logic        st2,  bi2,  bo2,  busy2,  done2;
  logic [1:0]  a2,   b2,   d2;
  logic        st16, bi16, bo16, busy16, done16;
  logic [15:0] a16,  b16,  d16;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  subtrator_serial #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .Bin(bi8),
    .D(d8), .Bout(bo8), .busy(busy8), .done(done8));
  subtrator_serial #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(st2), .A(a2), .B(b2), .Bin(bi2),
    .D(d2), .Bout(bo2), .busy(busy2), .done(done2));
  subtrator_serial #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16), .Bin(bi16),
    .D(d16), .Bout(bo16), .busy(busy16), .done(done16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, then reduce modulo 2^w.
  function automatic void ref_sub(input int w, input longint a, input longint b, input bit bi,
                                  output longint d, output bit bo);
    longint diff;
    diff = a - b - longint'(bi);
    bo   = (diff < 0);
    d    = diff & ((longint'(1) << w) - 1);
  endfunction

  // One WIDTH=8 operation; optionally keeps start high with new operands while busy.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb, input bit repulse, input string tag);
    logic [7:0] d_before;
    int idx, busyc;
    bit stable;
    @(negedge clk);
    d_before = d8;
    a8 = a; b8 = b; bi8 = bi; st8 = 1'b1;
    idx = 0; busyc = 0; stable = 1'b1;
    do begin
      @(negedge clk);
      idx++;
      if (busy8) busyc++;
      if (!done8 && d8 !== d_before) stable = 1'b0;
      st8 = repulse;
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    end while (!done8 && idx < 40);
    chk({tag, "_latency"}, 64'(idx), 64'd9);
    chk({tag, "_busy_cycles"}, 64'(busyc), 64'd9);
    chk({tag, "_d_stable"}, 64'(stable), 64'd1);
    chk({tag, "_d"}, 64'(d8), 64'(ed));
    chk({tag, "_bout"}, 64'(bo8), 64'(eb));
    @(negedge clk);
    st8 = 1'b0;
    chk({tag, "_idle_after"}, 64'({busy8, done8}), 64'd0);
    chk({tag, "_d_hold"}, 64'(d8), 64'(ed));
  endtask

  task automatic check_done(input string tag, input int w, input longint a, input longint b,
                            input bit bi, input longint d, input bit bo, input int cyc,
                            inout int last, inout int cnt);
    longint md;
    bit mb;
    ref_sub(w, a, b, bi, md, mb);
    chk({tag, "_d"}, 64'(d), 64'(md));
    chk({tag, "_bout"}, 64'(bo), 64'(mb));
    if (last >= 0) chk({tag, "_period"}, 64'(cyc - last), 64'(w + 2));
    last = cyc;
    cnt++;
  endtask

  initial begin
    longint md;
    bit mb;
    int l8, l2, l16, n8, n2, n16;

    rst = 1'b1;
    st8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    st2 = 0; a2 = 0; b2 = 0; bi2 = 0;
    st16 = 0; a16 = 0; b16 = 0; bi16 = 0;
    #12;
    chk("reset_d8", 64'(d8), 64'd0);
    chk("reset_bout8", 64'(bo8), 64'd0);
    chk("reset_busy_done8", 64'({busy8, done8}), 64'd0);
    chk("reset_d16", 64'({d16, bo16, busy16, done16}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "t1");
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "t2a");
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "t2b");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "t3a");
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, "t3b");

    // start re-pulsed with new operands during CALC and DONE must be ignored
    ref_sub(8, 64'h5A, 64'h3C, 1'b1, md, mb);
    op8(8'h5A, 8'h3C, 1'b1, 8'(md), mb, 1'b1, "t4");

    // Reset mid-calculation
    @(negedge clk);
    a8 = 8'h44; b8 = 8'h11; bi8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_d", 64'(d8), 64'd0);
    chk("t5_rst_bout", 64'(bo8), 64'd0);
    chk("t5_rst_busy_done", 64'({busy8, done8}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    op8(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, "t5_after");

    // start held high on all widths with random operands
    l8 = -1; l2 = -1; l16 = -1; n8 = 0; n2 = 0; n16 = 0;
    @(negedge clk);
    a8 = 8'($urandom);   b8 = 8'($urandom);   bi8 = 1'($urandom);
    a2 = 2'($urandom);   b2 = 2'($urandom);   bi2 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom);
    st8 = 1'b1; st2 = 1'b1; st16 = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (done8) begin
        check_done("t6_w8", 8, a8, b8, bi8, d8, bo8, cyc, l8, n8);
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      end
      if (done2) begin
        check_done("t6_w2", 2, a2, b2, bi2, d2, bo2, cyc, l2, n2);
        a2 = 2'($urandom); b2 = 2'($urandom); bi2 = 1'($urandom);
      end
      if (done16) begin
        check_done("t6_w16", 16, a16, b16, bi16, d16, bo16, cyc, l16, n16);
        a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom);
      end
    end
    st8 = 1'b0; st2 = 1'b0; st16 = 1'b0;
    chk("t6_w8_count_ok", 64'(n8 >= 38), 64'd1);
    chk("t6_w2_count_ok", 64'(n2 >= 98), 64'd1);
    chk("t6_w16_count_ok", 64'(n16 >= 21), 64'd1);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
